// File: rtl/i2c_mem_target.sv
// I2C target bridging the bus to a synchronous byte-wide memory with a loadable,
// auto-incrementing pointer. Define I2C_MEM_WP_EN to add the wp (write-protect) input.
module i2c_mem_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         MEM_AW      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  input  logic              sda,
`ifdef I2C_MEM_WP_EN
  input  logic              wp,
`endif
  output logic              sda_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEV     = 4'd1;
  localparam logic [3:0] DEV_ACK = 4'd2;
  localparam logic [3:0] PTR     = 4'd3;
  localparam logic [3:0] PTR_ACK = 4'd4;
  localparam logic [3:0] WR      = 4'd5;
  localparam logic [3:0] WR_ACK  = 4'd6;
  localparam logic [3:0] RD_LOAD = 4'd7;
  localparam logic [3:0] RD      = 4'd8;
  localparam logic [3:0] RD_ACK  = 4'd9;
  localparam logic [3:0] IGNORE  = 4'd10;

  logic [SYNC_STAGES-1:0] scl_p0, sda_p0;
  logic                   scl_p1, sda_p1;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  logic [3:0]        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift;
  logic [7:0]        byte_in;
  logic [MEM_AW-1:0] ptr;
  logic [MEM_AW-1:0] ptr_inc;
  logic              rw;
  logic              matched;
  logic              ack_bit;
  logic              last_bit;
  logic              wp_on;

  // Stage p0: synchronisers; p1: previous synchronised level for edge detection.
  // Not reset, so a reset in mid-transfer cannot fabricate a bus edge.
  always_ff @(posedge clk) begin
    scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl};
    sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda};
    scl_p1 <= scl_p0[SYNC_STAGES-1];
    sda_p1 <= sda_p0[SYNC_STAGES-1];
  end

  assign scl_s    = scl_p0[SYNC_STAGES-1];
  assign sda_s    = sda_p0[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p1;
  assign scl_fall = ~scl_s & scl_p1;
  assign start_c  = scl_s & scl_p1 & sda_p1 & ~sda_s;
  assign stop_c   = scl_s & scl_p1 & ~sda_p1 & sda_s;

  assign byte_in  = {shift[6:0], sda_s};
  assign last_bit = (bit_cnt == 4'd7);
  assign ptr_inc  = ptr + MEM_AW'(1);
  assign busy     = (state != IDLE) && (state != IGNORE);

`ifdef I2C_MEM_WP_EN
  assign wp_on = wp;
`else
  assign wp_on = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      ptr       <= '0;
      rw        <= 1'b0;
      matched   <= 1'b0;
      ack_bit   <= 1'b0;
      sda_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done   <= 1'b0;
      if (stop_c) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
        done    <= matched;
        matched <= 1'b0;
      end else if (start_c) begin
        // A repeated START keeps the pointer and the matched status.
        state   <= DEV;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
        if (state == IDLE) matched <= 1'b0;
      end else begin
        case (state)
          DEV: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state   <= DEV_ACK;
                  rw      <= byte_in[0];
                  matched <= 1'b1;
                  ack_bit <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                ptr     <= byte_in[MEM_AW-1:0];
                ack_bit <= 1'b1;
                state   <= PTR_ACK;
              end
            end
          end
          WR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                ack_bit <= ~wp_on;
                state   <= WR_ACK;
                if (!wp_on) begin
                  mem_addr  <= ptr;
                  mem_wdata <= byte_in;
                  mem_we    <= 1'b1;
                  ptr       <= ptr_inc;
                end
              end
            end
          end
          // bit_cnt 8: waiting for the fall that opens the ACK slot; 9: slot clocked.
          DEV_ACK, PTR_ACK, WR_ACK, RD_ACK: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= ack_bit;
            end else if (scl_rise && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd9;
              if (state == RD_ACK && sda_s) state <= IGNORE;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              if (state == DEV_ACK && !rw) begin
                state <= PTR;
              end else if (state == DEV_ACK || state == RD_ACK) begin
                state    <= RD_LOAD;
                mem_re   <= 1'b1;
                mem_addr <= ptr;
              end else begin
                state <= WR;
              end
            end
          end
          // mem_re is high on the first clk here; read data is captured on the second.
          RD_LOAD: begin
            if (!mem_re) begin
              shift   <= mem_rdata;
              sda_oe  <= ~mem_rdata[7];
              ptr     <= ptr_inc;
              bit_cnt <= 4'd0;
              state   <= RD;
            end
          end
          RD: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                ack_bit <= 1'b0;
                state   <= RD_ACK;
              end
            end else if (scl_fall) begin
              sda_oe <= ~shift[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
